// File: rtl/btn_input_ctrl.sv
// Memory-mapped button peripheral: synchronises and debounces four active-low buttons,
// latches press/release events, counts presses and returns a registered read word.
module btn_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btnUp,
   input  logic        btnDown,
   input  logic        btnLeft,
   input  logic        btnRight,
   input  logic        ren,
   input  logic [31:0] address,
   output logic [31:0] data_out
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]            btn_raw;
   logic [3:0]            sync1_q, sync2_q;
   logic [3:0]            smp;
   logic [3:0]            lvl_q, lvl_d;
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]            rise, fall;
   logic [3:0]            press_q, press_d;
   logic [3:0]            rel_q, rel_d;
   logic [3:0][7:0]       pcnt_q, pcnt_d;
   logic [31:0]           data_out_q, data_out_d;
   logic                  clr_press, clr_rel;
   logic                  unused_addr;

   assign btn_raw     = {btnRight, btnLeft, btnDown, btnUp};
   assign smp         = ~sync2_q;
   assign unused_addr = ^{address[31:4], address[1:0]};
   assign data_out    = data_out_q;

   // Any sample that disagrees with the current level for CntMax+1 cycles wins.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      rise  = '0;
      fall  = '0;
      for (int i = 0; i < 4; i++) begin
         if (smp[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            lvl_d[i] = smp[i];
            cnt_d[i] = '0;
            rise[i]  = smp[i];
            fall[i]  = ~smp[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   assign clr_press = ren && (address[3:2] == 2'd1);
   assign clr_rel   = ren && (address[3:2] == 2'd2);

   // A new event on the same edge as a clear-on-read keeps the flag set.
   always_comb begin
      press_d = (press_q & {4{~clr_press}}) | rise;
      rel_d   = (rel_q & {4{~clr_rel}}) | fall;
      pcnt_d  = pcnt_q;
      for (int i = 0; i < 4; i++) begin
         if (rise[i]) begin
            pcnt_d[i] = pcnt_q[i] + 8'd1;
         end
      end
   end

   always_comb begin
      data_out_d = data_out_q;
      if (ren) begin
         unique case (address[3:2])
            2'd0:    data_out_d = {28'b0, lvl_q};
            2'd1:    data_out_d = {28'b0, press_q};
            2'd2:    data_out_d = {28'b0, rel_q};
            default: data_out_d = {pcnt_q[3], pcnt_q[2], pcnt_q[1], pcnt_q[0]};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         lvl_q      <= '0;
         cnt_q      <= '0;
         press_q    <= '0;
         rel_q      <= '0;
         pcnt_q     <= '0;
         data_out_q <= '0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         lvl_q      <= lvl_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         pcnt_q     <= pcnt_d;
         data_out_q <= data_out_d;
      end
   end

endmodule
